// File: rtl/sdram_device_model.sv
// SDRAM chip-side responder: decodes the command bus, tracks per-bank open rows and
// the mode register, stores data in a reduced array and flags protocol violations.
module sdram_device_model #(
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_WIDTH    = 13,
    parameter int COL_WIDTH    = 9,
    parameter int BANK_WIDTH   = 2,
    parameter int MEM_ROW_BITS = 2,
    parameter int T_RCD        = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sdram_cke,
    input  logic                    sdram_ncs,
    input  logic                    sdram_nras,
    input  logic                    sdram_ncas,
    input  logic                    sdram_nwe,
    input  logic [BANK_WIDTH-1:0]   sdram_ba,
    input  logic [ROW_WIDTH-1:0]    sdram_a,
    input  logic [DATA_WIDTH/8-1:0] sdram_dqm,
    input  logic [DATA_WIDTH-1:0]   sdram_dq_i,
    output logic [DATA_WIDTH-1:0]   sdram_dq_o,
    output logic                    sdram_dq_oe,
    output logic [2:0]              mode_cas,
    output logic [15:0]             refresh_cnt,
    output logic                    err_valid,
    output logic [2:0]              err_code
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int NBANK  = 1 << BANK_WIDTH;
    localparam int ADDR_W = BANK_WIDTH + MEM_ROW_BITS + COL_WIDTH;
    localparam logic [4:0] TRCD_LIM = 5'(T_RCD);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_t;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    bank_state_t             bank_q [NBANK];
    bank_state_t             bank_d [NBANK];
    logic [MEM_ROW_BITS-1:0] row_q  [NBANK];
    logic [3:0]              trcd_q [NBANK];
    logic [DATA_WIDTH-1:0]   mem    [2**ADDR_W];

    cmd_t                  cmd;
    logic                  any_open, sel_open, trcd_short, mode_ok;
    logic                  err, act_go, wr_go, rd_go;
    logic [2:0]            code;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_a;

    logic                  rd_vld_p0, rd_cl3_p0, rd_vld_p1;
    logic [DATA_WIDTH-1:0] rd_data_p0, rd_data_p1;

    assign cmd        = (sdram_cke && !sdram_ncs) ? cmd_t'({sdram_nras, sdram_ncas, sdram_nwe}) : CMD_NOP;
    assign sel_open   = (bank_q[sdram_ba] == BANK_ACTIVE);
    assign trcd_short = ({1'b0, trcd_q[sdram_ba]} + 5'd1) < TRCD_LIM;
    assign mode_ok    = ((sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3)) && (sdram_a[2:0] == 3'd0);
    assign addr       = {sdram_ba, row_q[sdram_ba], sdram_a[COL_WIDTH-1:0]};
    assign unused_a   = ^sdram_a;
    assign err        = (code != 3'd0);
    assign act_go     = !err && (cmd == CMD_ACT);
    assign wr_go      = !err && (cmd == CMD_WR);
    assign rd_go      = !err && (cmd == CMD_RD);

    always_comb begin
        any_open = 1'b0;
        for (int i = 0; i < NBANK; i++)
            any_open = any_open | (bank_q[i] == BANK_ACTIVE);
    end

    // Error priority: NOT_INIT, BANK_IDLE, BANK_ACTIVE, TRCD, BANKS_OPEN, BAD_MODE
    always_comb begin
        code = 3'd0;
        case (cmd)
            CMD_ACT: begin
                if (mode_cas == 3'd0)  code = 3'd3;
                else if (sel_open)     code = 3'd2;
            end
            CMD_RD, CMD_WR: begin
                if (mode_cas == 3'd0)  code = 3'd3;
                else if (!sel_open)    code = 3'd1;
                else if (trcd_short)   code = 3'd4;
            end
            CMD_MRS: begin
                if (any_open)          code = 3'd5;
                else if (!mode_ok)     code = 3'd6;
            end
            CMD_REF: begin
                if (any_open)          code = 3'd5;
            end
            default: code = 3'd0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NBANK; i++)
            bank_d[i] = bank_q[i];
        if (!err) begin
            case (cmd)
                CMD_ACT: bank_d[sdram_ba] = BANK_ACTIVE;
                CMD_PRE: begin
                    if (sdram_a[10]) begin
                        for (int i = 0; i < NBANK; i++)
                            bank_d[i] = BANK_IDLE;
                    end else begin
                        bank_d[sdram_ba] = BANK_IDLE;
                    end
                end
                CMD_RD, CMD_WR: if (sdram_a[10]) bank_d[sdram_ba] = BANK_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < BYTES; b++)
            rd_word[b*8 +: 8] = sdram_dqm[b] ? 8'h00 : mem[addr][b*8 +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= BANK_IDLE;
                trcd_q[i] <= 4'd0;
            end
            mode_cas    <= 3'd0;
            refresh_cnt <= 16'd0;
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            rd_vld_p0   <= 1'b0;
            rd_cl3_p0   <= 1'b0;
            rd_vld_p1   <= 1'b0;
            sdram_dq_oe <= 1'b0;
            sdram_dq_o  <= '0;
        end else begin
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= bank_d[i];
                if (act_go && (sdram_ba == BANK_WIDTH'(i)))
                    trcd_q[i] <= 4'd0;
                else if (trcd_q[i] != 4'hF)
                    trcd_q[i] <= trcd_q[i] + 4'd1;
            end
            err_valid <= err;
            if (err)
                err_code <= code;
            if (!err && (cmd == CMD_MRS))
                mode_cas <= sdram_a[6:4];
            if (!err && (cmd == CMD_REF) && (refresh_cnt != 16'hFFFF))
                refresh_cnt <= refresh_cnt + 16'd1;
            // p0: word fetched at the RD edge, tagged with its CAS latency
            rd_vld_p0 <= rd_go;
            rd_cl3_p0 <= (mode_cas == 3'd3);
            // p1: extra delay for CL=3 only
            rd_vld_p1 <= rd_vld_p0 && rd_cl3_p0;
            // p2: DQ output register
            if (rd_vld_p1) begin
                sdram_dq_oe <= 1'b1;
                sdram_dq_o  <= rd_data_p1;
            end else if (rd_vld_p0 && !rd_cl3_p0) begin
                sdram_dq_oe <= 1'b1;
                sdram_dq_o  <= rd_data_p0;
            end else begin
                sdram_dq_oe <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (act_go)
            row_q[sdram_ba] <= sdram_a[MEM_ROW_BITS-1:0];
        if (wr_go) begin
            for (int b = 0; b < BYTES; b++)
                if (!sdram_dqm[b])
                    mem[addr][b*8 +: 8] <= sdram_dq_i[b*8 +: 8];
        end
        rd_data_p0 <= rd_word;
        rd_data_p1 <= rd_data_p0;
    end

endmodule

// File: tb/tb_sdram_device_model.sv
// Bench for sdram_device_model: directed scenarios plus a randomized command stream
// checked against a cycle-indexed behavioural model of the memory chip.
module tb_sdram_device_model;
    localparam int TRCD = 2;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_dqm;
    logic [15:0] sdram_dq_i, sdram_dq_o;
    logic        sdram_dq_oe, err_valid;
    logic [2:0]  mode_cas, err_code;
    logic [15:0] refresh_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Behavioural model state
    logic [15:0] m_mem  [8192];
    bit   [1:0]  m_kn   [8192];
    bit          m_open [4];
    int          m_row  [4];
    int          m_act  [4];
    int          m_mode, m_ref, m_errc;
    bit          m_errv;
    logic [15:0] m_rd   [int];
    bit          m_rdk  [int];

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    sdram_device_model #(
        .DATA_WIDTH(16), .ROW_WIDTH(13), .COL_WIDTH(9),
        .BANK_WIDTH(2), .MEM_ROW_BITS(2), .T_RCD(TRCD)
    ) dut (
        .clk(clk), .reset(reset),
        .sdram_cke(sdram_cke), .sdram_ncs(sdram_ncs),
        .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
        .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dqm(sdram_dqm),
        .sdram_dq_i(sdram_dq_i), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
        .mode_cas(mode_cas), .refresh_cnt(refresh_cnt),
        .err_valid(err_valid), .err_code(err_code)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_open[i] = 0;
        m_mode = 0; m_ref = 0; m_errv = 0; m_errc = 0;
        m_rd.delete();
        m_rdk.delete();
    endtask

    // Apply the chip rules to the command present at the current edge
    task automatic model_edge();
        logic [2:0]  c;
        logic [15:0] w;
        int code, b, ad;
        bit anyo, known;
        c    = (sdram_cke && !sdram_ncs) ? {sdram_nras, sdram_ncas, sdram_nwe} : C_NOP;
        b    = int'(sdram_ba);
        anyo = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        code = 0;
        case (c)
            C_ACT: if (m_mode == 0) code = 3; else if (m_open[b]) code = 2;
            C_RD, C_WR: begin
                if (m_mode == 0) code = 3;
                else if (!m_open[b]) code = 1;
                else if (edge_n - m_act[b] < TRCD) code = 4;
            end
            C_MRS: begin
                if (anyo) code = 5;
                else if (!((sdram_a[6:4] == 3'd2 || sdram_a[6:4] == 3'd3) && sdram_a[2:0] == 3'd0)) code = 6;
            end
            C_REF: if (anyo) code = 5;
            default: ;
        endcase
        m_errv = (code != 0);
        if (code != 0) m_errc = code;
        if (code == 0) begin
            ad = b * 2048 + (m_row[b] % 4) * 512 + int'(sdram_a[8:0]);
            case (c)
                C_ACT: begin m_open[b] = 1; m_row[b] = int'(sdram_a); m_act[b] = edge_n; end
                C_PRE: if (sdram_a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0; else m_open[b] = 0;
                C_WR: begin
                    if (!sdram_dqm[0]) begin m_mem[ad][7:0]  = sdram_dq_i[7:0];  m_kn[ad][0] = 1; end
                    if (!sdram_dqm[1]) begin m_mem[ad][15:8] = sdram_dq_i[15:8]; m_kn[ad][1] = 1; end
                    if (sdram_a[10]) m_open[b] = 0;
                end
                C_RD: begin
                    w = m_mem[ad];
                    known = (sdram_dqm[0] || m_kn[ad][0]) && (sdram_dqm[1] || m_kn[ad][1]);
                    if (sdram_dqm[0]) w[7:0]  = 8'h00;
                    if (sdram_dqm[1]) w[15:8] = 8'h00;
                    m_rd[edge_n + m_mode - 1]  = w;
                    m_rdk[edge_n + m_mode - 1] = known;
                    if (sdram_a[10]) m_open[b] = 0;
                end
                C_MRS: m_mode = int'(sdram_a[6:4]);
                C_REF: if (m_ref < 65535) m_ref++;
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                         input logic [1:0] m, input logic [15:0] d);
        sdram_cke = 1'b1; sdram_ncs = 1'b0;
        {sdram_nras, sdram_ncas, sdram_nwe} = c;
        sdram_ba = b; sdram_a = ad; sdram_dqm = m; sdram_dq_i = d;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (reset) model_reset(); else model_edge();
        #1;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                       input logic [1:0] m, input logic [15:0] d);
        drive(c, b, ad, m, d);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(C_NOP, 0, 0, 0, 0);
        model_reset();
        tick(); tick();
        n_checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_o !== 16'h0) begin n_fail++; $display("FAIL reset_dq: oe=%0b dq_o=%h, want 0/0000", sdram_dq_oe, sdram_dq_o); end
        n_checks++; if (mode_cas !== 3'd0 || refresh_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_regs: mode_cas=%0d refresh_cnt=%0d, want 0/0", mode_cas, refresh_cnt); end
        n_checks++; if (err_valid !== 1'b0 || err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err: err_valid=%0b err_code=%0d, want 0/0", err_valid, err_code); end
        reset = 1'b0;
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (err_valid !== 1'b0 || sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: err_valid=%0b oe=%0b, want 0/0", err_valid, sdram_dq_oe); end
    endtask

    task automatic test_not_init();
        cmd(C_RD, 0, 0, 0, 0);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd3) begin n_fail++; $display("FAIL not_init_rd: err_valid=%0b err_code=%0d, want 1/3", err_valid, err_code); end
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (err_valid !== 1'b0 || err_code !== 3'd3) begin n_fail++; $display("FAIL err_pulse_hold: err_valid=%0b err_code=%0d, want 0/3", err_valid, err_code); end
        cmd(C_ACT, 0, 0, 0, 0);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd3) begin n_fail++; $display("FAIL not_init_act: err_valid=%0b err_code=%0d, want 1/3", err_valid, err_code); end
    endtask

    task automatic test_write_basic();
        cmd(C_MRS, 0, 13'h020, 0, 0);
        n_checks++; if (mode_cas !== 3'd2 || err_valid !== 1'b0) begin n_fail++; $display("FAIL mrs_cl2: mode_cas=%0d err_valid=%0b, want 2/0", mode_cas, err_valid); end
        cmd(C_ACT, 1, 13'd5, 0, 0);
        cmd(C_NOP, 0, 0, 0, 0);
        cmd(C_WR, 1, 13'h403, 2'b00, 16'hA55A);
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL wr_autopre: err_valid=%0b, want 0", err_valid); end
        cmd(C_ACT, 1, 13'd5, 0, 0);
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL act_after_autopre: err_valid=%0b err_code=%0d, want 0", err_valid, err_code); end
    endtask

    task automatic test_read_basic();
        cmd(C_NOP, 0, 0, 0, 0);
        cmd(C_RD, 1, 13'd3, 2'b00, 0);
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rd_cl2_early: oe=%0b, want 0", sdram_dq_oe); end
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_o !== 16'hA55A) begin n_fail++; $display("FAIL rd_cl2_data: oe=%0b dq_o=%h, want 1/a55a", sdram_dq_oe, sdram_dq_o); end
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rd_cl2_release: oe=%0b, want 0", sdram_dq_oe); end
    endtask

    task automatic test_byte_mask();
        cmd(C_WR, 1, 13'd3, 2'b10, 16'h1234);
        cmd(C_RD, 1, 13'd3, 2'b00, 0);
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_o !== 16'hA534) begin n_fail++; $display("FAIL byte_mask_wr: oe=%0b dq_o=%h, want 1/a534", sdram_dq_oe, sdram_dq_o); end
        cmd(C_PRE, 0, 13'h400, 0, 0);
        cmd(C_MRS, 0, 13'h030, 0, 0);
        n_checks++; if (mode_cas !== 3'd3) begin n_fail++; $display("FAIL mrs_cl3: mode_cas=%0d, want 3", mode_cas); end
        cmd(C_ACT, 1, 13'd5, 0, 0);
        cmd(C_NOP, 0, 0, 0, 0);
        cmd(C_RD, 1, 13'd3, 2'b00, 0);
        cmd(C_RD, 1, 13'd3, 2'b01, 0);
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rd_cl3_early: oe=%0b, want 0", sdram_dq_oe); end
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_o !== 16'hA534) begin n_fail++; $display("FAIL rd_cl3_first: oe=%0b dq_o=%h, want 1/a534", sdram_dq_oe, sdram_dq_o); end
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_o !== 16'hA500) begin n_fail++; $display("FAIL rd_cl3_masked: oe=%0b dq_o=%h, want 1/a500", sdram_dq_oe, sdram_dq_o); end
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rd_cl3_release: oe=%0b, want 0", sdram_dq_oe); end
    endtask

    task automatic test_errors();
        cmd(C_PRE, 0, 13'h400, 0, 0);
        cmd(C_ACT, 0, 13'd0, 0, 0);
        cmd(C_ACT, 0, 13'd1, 0, 0);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd2) begin n_fail++; $display("FAIL bank_active: err_valid=%0b err_code=%0d, want 1/2", err_valid, err_code); end
        cmd(C_ACT, 2, 13'd0, 0, 0);
        cmd(C_RD, 2, 13'd0, 0, 0);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd4) begin n_fail++; $display("FAIL trcd: err_valid=%0b err_code=%0d, want 1/4", err_valid, err_code); end
        for (int i = 0; i < 3; i++) begin
            cmd(C_NOP, 0, 0, 0, 0);
            n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL trcd_no_read: oe=%0b at cycle %0d, want 0", sdram_dq_oe, i); end
        end
        cmd(C_REF, 0, 0, 0, 0);
        n_checks++; if (err_code !== 3'd5 || refresh_cnt !== 16'd0) begin n_fail++; $display("FAIL ref_open: err_code=%0d refresh_cnt=%0d, want 5/0", err_code, refresh_cnt); end
        cmd(C_RD, 3, 13'd0, 0, 0);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin n_fail++; $display("FAIL bank_idle: err_valid=%0b err_code=%0d, want 1/1", err_valid, err_code); end
        cmd(C_MRS, 0, 13'h020, 0, 0);
        n_checks++; if (err_code !== 3'd5 || mode_cas !== 3'd3) begin n_fail++; $display("FAIL mrs_open: err_code=%0d mode_cas=%0d, want 5/3", err_code, mode_cas); end
        cmd(C_PRE, 0, 13'h400, 0, 0);
        cmd(C_MRS, 0, 13'h050, 0, 0);
        n_checks++; if (err_code !== 3'd6 || mode_cas !== 3'd3) begin n_fail++; $display("FAIL bad_mode_cl: err_code=%0d mode_cas=%0d, want 6/3", err_code, mode_cas); end
        cmd(C_NOP, 0, 0, 0, 0);
        cmd(C_MRS, 0, 13'h031, 0, 0);
        n_checks++; if (err_valid !== 1'b1 || err_code !== 3'd6) begin n_fail++; $display("FAIL bad_mode_bl: err_valid=%0b err_code=%0d, want 1/6", err_valid, err_code); end
        cmd(C_REF, 0, 0, 0, 0);
        n_checks++; if (err_valid !== 1'b0 || refresh_cnt !== 16'd1) begin n_fail++; $display("FAIL ref_ok: err_valid=%0b refresh_cnt=%0d, want 0/1", err_valid, refresh_cnt); end
        drive(C_RD, 3, 0, 0, 0);
        sdram_ncs = 1'b1;
        tick();
        n_checks++; if (err_valid !== 1'b0 || err_code !== 3'd6) begin n_fail++; $display("FAIL deselect: err_valid=%0b err_code=%0d, want 0/6", err_valid, err_code); end
    endtask

    task automatic test_random();
        logic [12:0] mv [4];
        logic [2:0]  c;
        logic [12:0] ad;
        int op;
        bit exp_oe;
        mv[0] = 13'h020; mv[1] = 13'h030; mv[2] = 13'h050; mv[3] = 13'h021;
        cmd(C_PRE, 0, 13'h400, 0, 0);
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 4; r++) begin
                cmd(C_ACT, 2'(b), 13'(r), 0, 0);
                cmd(C_NOP, 0, 0, 0, 0);
                for (int col = 0; col < 4; col++) begin
                    cmd(C_WR, 2'(b), 13'(col) | ((col == 3) ? 13'h400 : 13'h0), 2'b00, 16'($urandom));
                    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL init_wr: err_valid=%0b err_code=%0d, want 0", err_valid, err_code); end
                end
            end
        end
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 99));
            ad = 13'($urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 13'h400 : 13'h0);
            if (op < 8)       c = C_NOP;
            else if (op < 10) c = 3'($urandom_range(0, 7));
            else if (op < 30) begin c = C_ACT; ad = 13'($urandom_range(0, 7)); end
            else if (op < 50) c = C_RD;
            else if (op < 68) c = C_WR;
            else if (op < 76) c = C_PRE;
            else if (op < 80) c = C_REF;
            else if (op < 84) begin c = C_MRS; ad = mv[$urandom_range(0, 3)]; end
            else              c = C_BST;
            drive(c, 2'($urandom_range(0, 1)), ad, 2'($urandom_range(0, 3)), 16'($urandom));
            if (op >= 8 && op < 10) begin
                if ($urandom_range(0, 1) == 0) sdram_ncs = 1'b1; else sdram_cke = 1'b0;
            end
            tick();
            n_checks++; if (err_valid !== m_errv || err_code !== 3'(m_errc)) begin n_fail++; $display("FAIL rand_err @%0d: err_valid=%0b err_code=%0d, want %0b/%0d", edge_n, err_valid, err_code, m_errv, m_errc); end
            n_checks++; if (mode_cas !== 3'(m_mode) || refresh_cnt !== 16'(m_ref)) begin n_fail++; $display("FAIL rand_regs @%0d: mode_cas=%0d refresh_cnt=%0d, want %0d/%0d", edge_n, mode_cas, refresh_cnt, m_mode, m_ref); end
            exp_oe = m_rd.exists(edge_n);
            n_checks++; if (sdram_dq_oe !== exp_oe) begin n_fail++; $display("FAIL rand_oe @%0d: oe=%0b, want %0b", edge_n, sdram_dq_oe, exp_oe); end
            if (exp_oe && m_rdk[edge_n]) begin
                n_checks++; if (sdram_dq_o !== m_rd[edge_n]) begin n_fail++; $display("FAIL rand_data @%0d: dq_o=%h, want %h", edge_n, sdram_dq_o, m_rd[edge_n]); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        cmd(C_PRE, 0, 13'h400, 0, 0);
        cmd(C_MRS, 0, 13'h020, 0, 0);
        cmd(C_ACT, 0, 13'd0, 0, 0);
        cmd(C_NOP, 0, 0, 0, 0);
        cmd(C_RD, 0, 13'd0, 2'b00, 0);
        #1 reset = 1'b1;
        model_reset();
        drive(C_NOP, 0, 0, 0, 0);
        #1;
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_pending_oe: oe=%0b, want 0", sdram_dq_oe); end
        tick();
        n_checks++; if (sdram_dq_oe !== 1'b0 || mode_cas !== 3'd0) begin n_fail++; $display("FAIL rst_flush: oe=%0b mode_cas=%0d, want 0/0", sdram_dq_oe, mode_cas); end
        reset = 1'b0;
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_no_late_read: oe=%0b, want 0", sdram_dq_oe); end
        cmd(C_MRS, 0, 13'h020, 0, 0);
        n_checks++; if (err_valid !== 1'b0 || mode_cas !== 3'd2) begin n_fail++; $display("FAIL rst_banks_idle: err_valid=%0b mode_cas=%0d, want 0/2", err_valid, mode_cas); end
        cmd(C_ACT, 0, 13'd0, 0, 0);
        cmd(C_NOP, 0, 0, 0, 0);
        cmd(C_RD, 0, 13'd0, 2'b11, 0);
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_o !== 16'h0000) begin n_fail++; $display("FAIL rd_full_mask: oe=%0b dq_o=%h, want 1/0000", sdram_dq_oe, sdram_dq_o); end
        #1 reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: oe=%0b, want 0", sdram_dq_oe); end
        tick();
        reset = 1'b0;
        cmd(C_NOP, 0, 0, 0, 0);
        n_checks++; if (sdram_dq_oe !== 1'b0 || mode_cas !== 3'd0 || err_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after: oe=%0b mode_cas=%0d err_valid=%0b, want 0/0/0", sdram_dq_oe, mode_cas, err_valid); end
    endtask

    initial begin
        reset = 1'b1;
        drive(C_NOP, 0, 0, 0, 0);
        test_reset();
        test_not_init();
        test_write_basic();
        test_read_basic();
        test_byte_mask();
        test_errors();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
